conway_frame_serializer: RTL and testbench



---
 rtl/conway_frame_serializer.sv | 143 ++++++++++++++
 tb/tb_conway_frame_serializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/conway_frame_serializer.sv
// Snapshots the Conway board on request and streams it out one row per valid/ready beat.
// Optional live-cell popcount: define CONWAY_SERIALIZER_POPCOUNT_EN.
module conway_frame_serializer #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ROWS*COLS-1:0]             cells_in,
  input  logic                             frame_req,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [COLS-1:0]                  out_data,
  output logic [$clog2(ROWS)-1:0]          out_row,
  output logic                             out_last,
  output logic                             busy,
  output logic                             frame_done,
  output logic [7:0]                       frame_count,
  output logic [$clog2(ROWS*COLS+1)-1:0]   live_count
);

  localparam int RW = $clog2(ROWS);
  localparam int LW = $clog2(ROWS*COLS+1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_end;
  logic [RW-1:0]         w_ptr_inc;
  logic [ROWS*COLS-1:0]  r_snap;
  logic [RW-1:0]         r_ptr;
  logic [COLS-1:0]       r_out_data;
  logic                  r_out_last;
  logic                  r_done;
  logic [7:0]            r_fcount;

  function automatic logic [COLS-1:0] row_of(input logic [ROWS*COLS-1:0] b,
                                             input logic [RW-1:0] r);
    return b[int'(r)*COLS +: COLS];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_req) begin
          w_start = 1'b1;
          w_next  = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          w_accept = 1'b1;
          if (r_ptr == LAST_ROW) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_end     = w_accept && (r_ptr == LAST_ROW);
  assign w_ptr_inc = r_ptr + RW'(1);

  // Output beat registers: the next row is preloaded at the accepting edge so
  // nothing downstream sees a path from out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap     <= '0;
      r_ptr      <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
      r_fcount   <= '0;
    end else begin
      r_done <= w_end;
      if (w_start) begin
        r_snap     <= cells_in;
        r_ptr      <= '0;
        r_out_data <= row_of(cells_in, '0);
        r_out_last <= 1'b0;
      end else if (w_end) begin
        r_ptr      <= '0;
        r_out_data <= '0;
        r_out_last <= 1'b0;
        r_fcount   <= r_fcount + 8'd1;
      end else if (w_accept) begin
        r_ptr      <= w_ptr_inc;
        r_out_data <= row_of(r_snap, w_ptr_inc);
        r_out_last <= (w_ptr_inc == LAST_ROW);
      end
    end
  end

`ifdef CONWAY_SERIALIZER_POPCOUNT_EN
  logic [LW-1:0] r_acc;
  logic [LW-1:0] r_live;

  function automatic logic [LW-1:0] popcnt(input logic [COLS-1:0] v);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + LW'(v[i]);
    return n;
  endfunction

  // Total is published only on a completed frame; an aborted frame leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_live <= '0;
    end else if (w_start) begin
      r_acc <= '0;
    end else if (w_end) begin
      r_live <= r_acc + popcnt(r_out_data);
    end else if (w_accept) begin
      r_acc <= r_acc + popcnt(r_out_data);
    end
  end

  assign live_count = r_live;
`else
  assign live_count = '0;
`endif

  assign out_valid   = (r_state == S_SEND);
  assign busy        = (r_state == S_SEND);
  assign out_data    = r_out_data;
  assign out_row     = r_ptr;
  assign out_last    = r_out_last;
  assign frame_done  = r_done;
  assign frame_count = r_fcount;

endmodule

// File: tb/tb_conway_frame_serializer.sv
// Randomized bench for conway_frame_serializer (8x8) against a row-queue reference model.
module tb_conway_frame_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cells_in;
  logic        frame_req;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_row;
  logic        out_last;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic [6:0]  live_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_fc   = 0;
  int exp_live = 0;

  conway_frame_serializer #(.ROWS(8), .COLS(8)) dut (
    .clk(clk), .rst(rst), .cells_in(cells_in), .frame_req(frame_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .live_count(live_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int live_of(input logic [63:0] b);
`ifdef CONWAY_SERIALIZER_POPCOUNT_EN
    return $countones(b);
`else
    return 0;
`endif
  endfunction

  function automatic logic [7:0] row_word(input logic [63:0] b, input int r);
    return b[r*8 +: 8];
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"},  out_data, 0);
    chk({tag, "_row"},   out_row, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  frame_done, 0);
    chk({tag, "_fcount"}, frame_count, 0);
    chk({tag, "_live"},  live_count, 0);
  endtask

  // Called at a negedge with the DUT idle (or in its frame_done cycle).
  // mode 0: ready always high; 1: ready pattern 1,0,0; 2: random ready.
  task automatic run_frame(input logic [63:0] board, input int mode);
    logic [7:0] rows_q[$];
    logic       rdy;
    int         cyc;
    int         idx;
    for (int r = 0; r < 8; r++) rows_q.push_back(row_word(board, r));
    cells_in  = board;
    frame_req = 1'b1;
    out_ready = (mode == 0);
    @(negedge clk);
    frame_req = 1'b0;
    cyc = 0;
    idx = 0;
    while (rows_q.size() > 0 && cyc < 200) begin
      chk("beat_valid", out_valid, 1);
      chk("beat_busy", busy, 1);
      chk("beat_data", out_data, rows_q[0]);
      chk("beat_row", out_row, 8 - rows_q.size());
      chk("beat_last", out_last, rows_q.size() == 1);
      chk("beat_nodone", frame_done, 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (idx % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      cells_in  = {$urandom, $urandom};
      frame_req = 1'($urandom_range(0, 1));
      idx++;
      cyc++;
      @(negedge clk);
      if (rdy) void'(rows_q.pop_front());
    end
    chk("frame_timeout", rows_q.size(), 0);
    if (mode == 0) chk("frame_beats", cyc, 8);
    frame_req = 1'b0;
    out_ready = 1'b0;
    exp_fc   = (exp_fc + 1) % 256;
    exp_live = live_of(board);
    chk("end_done", frame_done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", out_valid, 0);
    chk("end_fcount", frame_count, exp_fc);
    chk("end_live", live_count, exp_live);
  endtask

  initial begin
    logic [63:0] board;
    int          base;
    int          ph;

    rst = 1'b1; frame_req = 1'b0; out_ready = 1'b0; cells_in = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");

    // Reset beats a simultaneous request.
    frame_req = 1'b1;
    cells_in  = '1;
    @(negedge clk);
    chk("rstprio_valid", out_valid, 0);
    chk("rstprio_busy", busy, 0);
    rst = 1'b0;
    frame_req = 1'b0;
    @(negedge clk);
    chk("idle_valid", out_valid, 0);

    // Single frame: blinker in row 1.
    run_frame(64'h0000_0000_0000_0700, 0);

    // Backpressure with scrambled live input, then random handshakes.
    run_frame({$urandom, $urandom}, 1);
    for (int i = 0; i < 6; i++) run_frame({$urandom, $urandom}, 2);

    // Request held high: a new frame every 9 cycles, no restarts.
    board     = {$urandom, $urandom};
    cells_in  = board;
    out_ready = 1'b1;
    frame_req = 1'b1;
    base      = exp_fc;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      ph = (c - 1) % 9;
      if (ph < 8) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_row", out_row, ph);
        chk("hold_data", out_data, row_word(board, ph));
        chk("hold_nodone", frame_done, 0);
      end else begin
        chk("hold_gap_valid", out_valid, 0);
        chk("hold_done", frame_done, 1);
      end
      if (c == 27) frame_req = 1'b0;
    end
    exp_fc   = (base + 3) % 256;
    exp_live = live_of(board);
    chk("hold_fcount", frame_count, exp_fc);
    chk("hold_live", live_count, exp_live);

    // Mid-frame reset after four accepted beats.
    cells_in  = {$urandom, $urandom};
    frame_req = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_row_before", out_row, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    chk_reset_vals("abort");
    exp_fc   = 0;
    exp_live = 0;
    @(negedge clk);
    chk("abort_nodone", frame_done, 0);
    chk("abort_idle", out_valid, 0);
    run_frame({$urandom, $urandom}, 2);

    // 256 all-ones frames: frame_count wraps through 255 -> 0.
    for (int i = 0; i < 256; i++) run_frame('1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
